// File: rtl/shear_sort_pe_pkg.sv
`default_nettype none
// ============================================================================
// Package     : nanci_pkg
// Description : Shared types and constants for the shearsort mesh PE:
//               FSM state codes, partner-select codes, keep-min/max flags
//               and a constant clog2 helper.
// Revision    : 1.0 - initial release
// ============================================================================
package nanci_pkg;

   // FSM state encoding
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ROW  = 2'd1;
   localparam logic [1:0] ST_COL  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   // Which neighbour this PE is paired with in the current step
   localparam logic [2:0] PSEL_NONE = 3'd0;
   localparam logic [2:0] PSEL_L    = 3'd1;
   localparam logic [2:0] PSEL_R    = 3'd2;
   localparam logic [2:0] PSEL_U    = 3'd3;
   localparam logic [2:0] PSEL_D    = 3'd4;

   // Exchange direction: keep the smaller or the larger key
   localparam logic KEEP_MIN = 1'b1;
   localparam logic KEEP_MAX = 1'b0;

   // Ceiling log2 for elaboration-time width calculations
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/shear_sort_pe_if.sv
`default_nettype none
// ============================================================================
// Interface   : shear_sort_pe_if
// Description : Load handshake and sort control/status bundle of one PE.
//               The PE is the slave; the mesh controller is the master.
// Revision    : 1.0 - initial release
// ============================================================================
interface shear_sort_pe_if #(
   parameter int DATA_WIDTH = 16
) ();
   logic                  i_load_valid;
   logic [DATA_WIDTH-1:0] i_load_data;
   logic                  o_load_ready;
   logic                  i_start;
   logic                  o_busy;
   logic                  o_done;

   modport slave (
      input  i_load_valid,
      input  i_load_data,
      input  i_start,
      output o_load_ready,
      output o_busy,
      output o_done
   );

   modport master (
      output i_load_valid,
      output i_load_data,
      output i_start,
      input  o_load_ready,
      input  o_busy,
      input  o_done
   );
endinterface
`default_nettype wire

// File: rtl/shear_sort_pe_cmp_exchange.sv
`default_nettype none
// ============================================================================
// Module      : cmp_exchange
// Description : Combinational compare-exchange. Returns the neighbour record
//               only when its key is strictly better than our own; equal
//               keys keep our own record so both partners stay consistent.
// Revision    : 1.0 - initial release
// ============================================================================
module cmp_exchange #(
   parameter int DATA_WIDTH = 16,
   parameter int KEY_WIDTH  = 8
) (
   input  logic [DATA_WIDTH-1:0] own,
   input  logic [DATA_WIDTH-1:0] nbr,
   input  logic                  keep_min,
   output logic [DATA_WIDTH-1:0] chosen
);

   logic [KEY_WIDTH-1:0] own_key;
   logic [KEY_WIDTH-1:0] nbr_key;
   logic                 nbr_better;

   // Key extraction (MSBs) and strict-improvement selection
   always_comb begin
      own_key    = own[DATA_WIDTH-1 -: KEY_WIDTH];
      nbr_key    = nbr[DATA_WIDTH-1 -: KEY_WIDTH];
      nbr_better = keep_min ? (nbr_key < own_key) : (nbr_key > own_key);
      chosen     = nbr_better ? nbr : own;
   end

endmodule
`default_nettype wire

// File: rtl/shear_sort_pe.sv
`default_nettype none
// ============================================================================
// Module      : shear_sort_pe
// Description : Shearsort mesh processing element. Holds one record, loads
//               it through a valid/ready handshake and then runs alternating
//               snake-ordered row phases and ascending column phases of
//               odd-even transposition against its four neighbours.
//               Optional macro SORT_STATS_EN adds o_swap_cnt, the number of
//               steps in which the record was replaced by a neighbour's.
// Revision    : 1.0 - initial release
// ============================================================================
module shear_sort_pe
   import nanci_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int KEY_WIDTH  = 8,
   parameter int SQRT_N     = 4,
   parameter int ROW        = 0,
   parameter int COL        = 0,
   parameter int NUM_ROUNDS = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   shear_sort_pe_if.slave        ctrl,
   input  logic [DATA_WIDTH-1:0] i_PE_l,
   input  logic [DATA_WIDTH-1:0] i_PE_r,
   input  logic [DATA_WIDTH-1:0] i_PE_u,
   input  logic [DATA_WIDTH-1:0] i_PE_d,
   output logic [DATA_WIDTH-1:0] o_PE
`ifdef SORT_STATS_EN
   ,
   output logic [clog2(NUM_ROUNDS*2*SQRT_N+1)-1:0] o_swap_cnt
`endif
);

   localparam int STEP_W  = (SQRT_N > 1)     ? clog2(SQRT_N)     : 1;
   localparam int ROUND_W = (NUM_ROUNDS > 1) ? clog2(NUM_ROUNDS) : 1;

   localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(SQRT_N - 1);
   localparam logic [ROUND_W-1:0] ROUND_LAST = ROUND_W'(NUM_ROUNDS - 1);

   // Position-derived constants: parity and mesh-edge flags
   localparam logic ROW_ODD   = (ROW % 2) == 1;
   localparam logic COL_ODD   = (COL % 2) == 1;
   localparam logic AT_LEFT   = (COL == 0);
   localparam logic AT_RIGHT  = (COL == SQRT_N - 1);
   localparam logic AT_TOP    = (ROW == 0);
   localparam logic AT_BOTTOM = (ROW == SQRT_N - 1);

   logic [1:0]            state;
   logic [STEP_W-1:0]     step_cnt;
   logic [ROUND_W-1:0]    round_cnt;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  armed;

   logic [2:0]            psel;
   logic                  keep_min;
   logic [DATA_WIDTH-1:0] nbr;
   logic [DATA_WIDTH-1:0] chosen;
   logic                  exchange;
   logic                  load_fire;
   logic                  start_fire;

   assign ctrl.o_load_ready = armed & (state == ST_IDLE);
   assign ctrl.o_busy       = (state == ST_ROW) | (state == ST_COL);
   assign ctrl.o_done       = (state == ST_DONE);
   assign o_PE              = data_q;

   assign load_fire  = ctrl.i_load_valid & ctrl.o_load_ready;
   assign start_fire = ctrl.i_start & (state == ST_IDLE);
   assign exchange   = (psel != PSEL_NONE);

   // Partner selection and exchange direction for the current step.
   // (pos + t) even pairs with the higher-index neighbour; step_cnt[0]
   // equal to the position parity is exactly that case.
   always_comb begin
      psel     = PSEL_NONE;
      keep_min = KEEP_MIN;
      case (state)
         ST_ROW: begin
            if (COL_ODD == step_cnt[0]) begin
               psel     = AT_RIGHT ? PSEL_NONE : PSEL_R;
               keep_min = ROW_ODD ? KEEP_MAX : KEEP_MIN;
            end else begin
               psel     = AT_LEFT ? PSEL_NONE : PSEL_L;
               keep_min = ROW_ODD ? KEEP_MIN : KEEP_MAX;
            end
         end
         ST_COL: begin
            if (ROW_ODD == step_cnt[0]) begin
               psel     = AT_BOTTOM ? PSEL_NONE : PSEL_D;
               keep_min = KEEP_MIN;
            end else begin
               psel     = AT_TOP ? PSEL_NONE : PSEL_U;
               keep_min = KEEP_MAX;
            end
         end
         default: begin
            psel     = PSEL_NONE;
            keep_min = KEEP_MIN;
         end
      endcase
   end

   // Neighbour record multiplexer
   always_comb begin
      nbr = data_q;
      case (psel)
         PSEL_L:  nbr = i_PE_l;
         PSEL_R:  nbr = i_PE_r;
         PSEL_U:  nbr = i_PE_u;
         PSEL_D:  nbr = i_PE_d;
         default: nbr = data_q;
      endcase
   end

   cmp_exchange #(
      .DATA_WIDTH (DATA_WIDTH),
      .KEY_WIDTH  (KEY_WIDTH)
   ) u_cmp (
      .own      (data_q),
      .nbr      (nbr),
      .keep_min (keep_min),
      .chosen   (chosen)
   );

   // Phase sequencing: step counter, round counter and state transitions
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         step_cnt  <= '0;
         round_cnt <= '0;
         armed     <= 1'b0;
      end else begin
         armed <= 1'b1;
         case (state)
            ST_IDLE: begin
               if (start_fire) begin
                  state     <= ST_ROW;
                  step_cnt  <= '0;
                  round_cnt <= '0;
               end
            end
            ST_ROW: begin
               if (step_cnt == STEP_LAST) begin
                  step_cnt <= '0;
                  state    <= (round_cnt == ROUND_LAST) ? ST_DONE : ST_COL;
               end else begin
                  step_cnt <= step_cnt + 1'b1;
               end
            end
            ST_COL: begin
               if (step_cnt == STEP_LAST) begin
                  step_cnt  <= '0;
                  round_cnt <= round_cnt + 1'b1;
                  state     <= ST_ROW;
               end else begin
                  step_cnt <= step_cnt + 1'b1;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Record register: loaded in IDLE, compare-exchanged during phases
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_q <= '0;
      end else if (load_fire) begin
         data_q <= ctrl.i_load_data;
      end else if (exchange) begin
         data_q <= chosen;
      end
   end

`ifdef SORT_STATS_EN
   localparam int SWAP_W = clog2(NUM_ROUNDS*2*SQRT_N+1);
   localparam logic [SWAP_W-1:0] SWAP_MAX = '1;

   logic [SWAP_W-1:0] swap_cnt;
   logic              took_nbr;

   assign took_nbr   = exchange & (chosen != data_q);
   assign o_swap_cnt = swap_cnt;

   // Saturating count of steps that replaced the record
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         swap_cnt <= '0;
      end else if (start_fire) begin
         swap_cnt <= '0;
      end else if (took_nbr && (swap_cnt != SWAP_MAX)) begin
         swap_cnt <= swap_cnt + 1'b1;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_shear_sort_pe.sv
`default_nettype none
// ============================================================================
// Module      : tb_shear_sort_pe
// Description : Directed self-checking bench for shear_sort_pe: two single
//               PEs with bench-driven neighbours plus a full 4x4 mesh.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shear_sort_pe;

   logic clk   = 1'b0;
   logic rst   = 1'b0;
   logic rst_m = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   // ---------------- single PEs ----------------
   shear_sort_pe_if #(.DATA_WIDTH(16)) if0 ();
   shear_sort_pe_if #(.DATA_WIDTH(16)) if1 ();

   logic [15:0] l0, r0, u0, d0, pe0;
   logic [15:0] l1, r1, u1, d1, pe1;
`ifdef SORT_STATS_EN
   logic [4:0] swap0, swap1;
`endif

   shear_sort_pe #(.ROW(0), .COL(0)) u_pe0 (
      .clk    (clk),
      .rst    (rst),
      .ctrl   (if0),
      .i_PE_l (l0),
      .i_PE_r (r0),
      .i_PE_u (u0),
      .i_PE_d (d0),
      .o_PE   (pe0)
`ifdef SORT_STATS_EN
      , .o_swap_cnt (swap0)
`endif
   );

   shear_sort_pe #(.ROW(1), .COL(0)) u_pe1 (
      .clk    (clk),
      .rst    (rst),
      .ctrl   (if1),
      .i_PE_l (l1),
      .i_PE_r (r1),
      .i_PE_u (u1),
      .i_PE_d (d1),
      .o_PE   (pe1)
`ifdef SORT_STATS_EN
      , .o_swap_cnt (swap1)
`endif
   );

   // ---------------- 4x4 mesh ----------------
   logic        m_load_valid;
   logic        m_start;
   logic [15:0] m_load_data [16];
   logic [15:0] m_pe        [16];
   logic [15:0] m_busy;
   logic [15:0] m_done;
   logic [15:0] m_ready;
`ifdef SORT_STATS_EN
   logic [4:0]  m_swap      [16];
`endif

   for (genvar r = 0; r < 4; r++) begin : g_row
      for (genvar c = 0; c < 4; c++) begin : g_col
         localparam int IDX = r*4 + c;
         localparam int IL  = (c > 0) ? IDX - 1 : IDX;
         localparam int IR  = (c < 3) ? IDX + 1 : IDX;
         localparam int IU  = (r > 0) ? IDX - 4 : IDX;
         localparam int ID  = (r < 3) ? IDX + 4 : IDX;
         shear_sort_pe_if #(.DATA_WIDTH(16)) mif ();
         assign mif.i_load_valid = m_load_valid;
         assign mif.i_load_data  = m_load_data[IDX];
         assign mif.i_start      = m_start;
         assign m_busy[IDX]      = mif.o_busy;
         assign m_done[IDX]      = mif.o_done;
         assign m_ready[IDX]     = mif.o_load_ready;
         shear_sort_pe #(.ROW(r), .COL(c)) u_pe (
            .clk    (clk),
            .rst    (rst_m),
            .ctrl   (mif),
            .i_PE_l ((c > 0) ? m_pe[IL] : 16'h0000),
            .i_PE_r ((c < 3) ? m_pe[IR] : 16'h0000),
            .i_PE_u ((r > 0) ? m_pe[IU] : 16'h0000),
            .i_PE_d ((r < 3) ? m_pe[ID] : 16'h0000),
            .o_PE   (m_pe[IDX])
`ifdef SORT_STATS_EN
            , .o_swap_cnt (m_swap[IDX])
`endif
         );
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- reset ----------------
   task automatic test_reset();
      if0.i_load_valid = 1'b1; if0.i_load_data = 16'h1234; if0.i_start = 1'b0;
      if1.i_load_valid = 1'b0; if1.i_load_data = 16'h0000; if1.i_start = 1'b0;
      m_load_valid = 1'b0; m_start = 1'b0;
      for (int i = 0; i < 16; i++) m_load_data[i] = 16'h0000;
      l0 = '0; r0 = '0; u0 = '0; d0 = '0;
      l1 = '0; r1 = '0; u1 = '0; d1 = '0;
      rst = 1'b0; rst_m = 1'b0;
      repeat (3) tick();
      checks++;
      if (pe0 !== 16'h0000) begin
         errors++; $display("FAIL reset_o_PE: got %h expected 0000", pe0);
      end
      checks++;
      if (if0.o_load_ready !== 1'b0) begin
         errors++; $display("FAIL reset_ready_in_reset: got %b expected 0", if0.o_load_ready);
      end
      if0.i_load_valid = 1'b0;
      rst = 1'b1; rst_m = 1'b1;
      repeat (2) tick();
      checks++;
      if (if0.o_load_ready !== 1'b1) begin
         errors++; $display("FAIL reset_ready_after: got %b expected 1", if0.o_load_ready);
      end
      checks++;
      if ({if0.o_busy, if0.o_done} !== 2'b00) begin
         errors++; $display("FAIL reset_busy_done: got %b expected 00", {if0.o_busy, if0.o_done});
      end
      checks++;
      if (pe0 !== 16'h0000) begin
         errors++; $display("FAIL reset_o_PE_after: got %h expected 0000", pe0);
      end
      checks++;
      if (m_ready !== 16'hFFFF) begin
         errors++; $display("FAIL reset_mesh_ready: got %h expected ffff", m_ready);
      end
   endtask

   // ---------------- even row exchange, left-edge hold ----------------
   task automatic test_row_exchange();
      logic got;
      if0.i_load_valid = 1'b1; if0.i_load_data = 16'h50AA;
      tick();
      if0.i_load_valid = 1'b0;
      checks++;
      if (pe0 !== 16'h50AA) begin
         errors++; $display("FAIL row_load: got %h expected 50aa", pe0);
      end
      l0 = 16'h0000; r0 = 16'h3011; u0 = 16'h0000; d0 = 16'hFFFF;
      if0.i_start = 1'b1;
      tick();
      if0.i_start = 1'b0;
      checks++;
      if (if0.o_busy !== 1'b1) begin
         errors++; $display("FAIL row_busy: got %b expected 1", if0.o_busy);
      end
      tick();
      checks++;
      if (pe0 !== 16'h3011) begin
         errors++; $display("FAIL row_step0_take_right: got %h expected 3011", pe0);
      end
      tick();
      checks++;
      if (pe0 !== 16'h3011) begin
         errors++; $display("FAIL row_step1_edge_hold: got %h expected 3011", pe0);
      end
      got = 1'b0;
      for (int k = 0; k < 40 && !got; k++) begin
         tick();
         if (if0.o_done === 1'b1) got = 1'b1;
      end
      checks++;
      if (got !== 1'b1) begin
         errors++; $display("FAIL row_done_timeout: got %b expected 1", got);
      end
      checks++;
      if (pe0 !== 16'h3011) begin
         errors++; $display("FAIL row_final: got %h expected 3011", pe0);
      end
`ifdef SORT_STATS_EN
      checks++;
      if (swap0 !== 5'd1) begin
         errors++; $display("FAIL stats_swap_count: got %0d expected 1", swap0);
      end
`endif
      tick();
   endtask

   // ---------------- swap counter hold and clear ----------------
   task automatic test_stats();
`ifdef SORT_STATS_EN
      logic got;
      repeat (2) tick();
      checks++;
      if (swap0 !== 5'd1) begin
         errors++; $display("FAIL stats_hold_idle: got %0d expected 1", swap0);
      end
      if0.i_start = 1'b1;
      tick();
      if0.i_start = 1'b0;
      checks++;
      if (swap0 !== 5'd0) begin
         errors++; $display("FAIL stats_clear_on_start: got %0d expected 0", swap0);
      end
      got = 1'b0;
      for (int k = 0; k < 40 && !got; k++) begin
         tick();
         if (if0.o_done === 1'b1) got = 1'b1;
      end
      checks++;
      if (got !== 1'b1) begin
         errors++; $display("FAIL stats_done_timeout: got %b expected 1", got);
      end
      tick();
`endif
   endtask

   // ---------------- odd row keeps max, equal keys keep own ----------------
   task automatic test_odd_row();
      logic got;
      if1.i_load_valid = 1'b1; if1.i_load_data = 16'h3022;
      l1 = 16'h0000; r1 = 16'h5044; u1 = 16'h0000; d1 = 16'hFFFF;
      tick();
      if1.i_load_valid = 1'b0;
      if1.i_start = 1'b1;
      tick();
      if1.i_start = 1'b0;
      tick();
      checks++;
      if (pe1 !== 16'h5044) begin
         errors++; $display("FAIL odd_row_keep_max: got %h expected 5044", pe1);
      end
      got = 1'b0;
      for (int k = 0; k < 40 && !got; k++) begin
         tick();
         if (if1.o_done === 1'b1) got = 1'b1;
      end
      checks++;
      if (got !== 1'b1) begin
         errors++; $display("FAIL odd_row_done_timeout: got %b expected 1", got);
      end
      tick();
      if1.i_load_valid = 1'b1; if1.i_load_data = 16'h50AA;
      r1 = 16'h50BB;
      tick();
      if1.i_load_valid = 1'b0;
      if1.i_start = 1'b1;
      tick();
      if1.i_start = 1'b0;
      tick();
      checks++;
      if (pe1 !== 16'h50AA) begin
         errors++; $display("FAIL equal_key_keep_own: got %h expected 50aa", pe1);
      end
      got = 1'b0;
      for (int k = 0; k < 40 && !got; k++) begin
         tick();
         if (if1.o_done === 1'b1) got = 1'b1;
      end
      checks++;
      if (pe1 !== 16'h50AA || got !== 1'b1) begin
         errors++; $display("FAIL equal_key_final: got %h/%b expected 50aa/1", pe1, got);
      end
      tick();
   endtask

   // ---------------- default latency, start/load ignored while busy ----------------
   task automatic test_timing();
      if0.i_start = 1'b1;
      tick();
      if0.i_start = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         checks++;
         if ({if0.o_busy, if0.o_done} !== 2'b10) begin
            errors++;
            $display("FAIL timing_busy_cycle%0d: got busy/done %b expected 10",
                     k, {if0.o_busy, if0.o_done});
         end
         if (k == 5) begin
            if0.i_start = 1'b1; if0.i_load_valid = 1'b1; if0.i_load_data = 16'hEEEE;
         end else begin
            if0.i_start = 1'b0; if0.i_load_valid = 1'b0;
         end
         tick();
      end
      checks++;
      if ({if0.o_busy, if0.o_done} !== 2'b01) begin
         errors++; $display("FAIL timing_done_cycle21: got busy/done %b expected 01",
                            {if0.o_busy, if0.o_done});
      end
      tick();
      checks++;
      if ({if0.o_done, if0.o_load_ready} !== 2'b01) begin
         errors++; $display("FAIL timing_idle_cycle22: got done/ready %b expected 01",
                            {if0.o_done, if0.o_load_ready});
      end
      checks++;
      if (pe0 !== 16'h3011) begin
         errors++; $display("FAIL timing_busy_load_ignored: got %h expected 3011", pe0);
      end
   endtask

   // ---------------- full 4x4 mesh ----------------
   task automatic mesh_run(input string tag);
      logic got;
      int   p;
      logic [15:0] exp_v;
      got = 1'b0;
      for (int k = 0; k < 40 && !got; k++) begin
         tick();
         if (m_done[0] === 1'b1) got = 1'b1;
      end
      checks++;
      if (got !== 1'b1) begin
         errors++; $display("FAIL %s_done_timeout: got %b expected 1", tag, got);
      end
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            p = (r % 2 == 0) ? r*4 + c : r*4 + 3 - c;
            exp_v = {p[7:0], p[7:0]};
            checks++;
            if (m_pe[r*4+c] !== exp_v) begin
               errors++;
               $display("FAIL %s_cell_r%0d_c%0d: got %h expected %h", tag, r, c, m_pe[r*4+c], exp_v);
            end
         end
      end
   endtask

   task automatic mesh_load_start();
      for (int i = 0; i < 16; i++) m_load_data[i] = {8'(15 - i), 8'(15 - i)};
      m_load_valid = 1'b1;
      tick();
      m_load_valid = 1'b0;
      m_start = 1'b1;
      tick();
      m_start = 1'b0;
   endtask

   task automatic test_mesh();
      mesh_load_start();
      mesh_run("mesh");
      tick();
      mesh_load_start();
      repeat (6) tick();
      checks++;
      if (m_busy !== 16'hFFFF) begin
         errors++; $display("FAIL mesh_midsort_busy: got %h expected ffff", m_busy);
      end
      rst_m = 1'b0;
      #2;
      checks++;
      if (m_pe[5] !== 16'h0000 || m_busy !== 16'h0000) begin
         errors++; $display("FAIL mesh_async_reset: got pe %h busy %h expected 0000/0000",
                            m_pe[5], m_busy);
      end
      tick();
      rst_m = 1'b1;
      repeat (2) tick();
      mesh_load_start();
      mesh_run("mesh_restart");
   endtask

   initial begin
      test_reset();
      test_row_exchange();
      test_stats();
      test_odd_row();
      test_timing();
      test_mesh();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
